// File: rtl/alu_exec_controller_pkg.sv
// Shared opcode, ALU selectOp and FSM state definitions for the execute sequencer.
// The ALU beside this block decodes the same selectOp constants.
package alu_exec_controller_pkg;

    localparam logic [2:0] OP_CLR   = 3'd0;
    localparam logic [2:0] OP_PASS  = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_INC   = 3'd5;
    localparam logic [2:0] OP_STORE = 3'd6;
    localparam logic [2:0] OP_NOP   = 3'd7;

    localparam logic [2:0] ALU_CLR  = 3'd0;
    localparam logic [2:0] ALU_PASS = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;
    localparam logic [2:0] ALU_MUL  = 3'd4;
    localparam logic [2:0] ALU_INC  = 3'd5;
    localparam logic [2:0] ALU_IDLE = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WRITE
    } state_t;

    function automatic logic needs_fetch(input logic [2:0] op);
        return (op == OP_PASS) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

    // Opcodes that reach EXEC map onto ALU selects; anything else leaves the ALU idle.
    function automatic logic [2:0] alu_sel_for(input logic [2:0] op);
        logic [2:0] sel;
        case (op)
            OP_CLR:  sel = ALU_CLR;
            OP_PASS: sel = ALU_PASS;
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_MUL:  sel = ALU_MUL;
            OP_INC:  sel = ALU_INC;
            default: sel = ALU_IDLE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_exec_controller.sv
// Execute sequencer upstream of the ALU: accepts one instruction, fetches an operand
// if required, drives the ALU and latches its result into the accumulator.
module alu_exec_controller
    import alu_exec_controller_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            instr_op,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rd_valid,
    input  logic [WIDTH-1:0]      mem_rd_data,
    output logic                  mem_wr_en,
    output logic [WIDTH-1:0]      mem_wr_data,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [2:0]            alu_sel,
    input  logic [WIDTH-1:0]      alu_result,
    output logic [WIDTH-1:0]      acc_out,
    output logic                  zero_flag,
    output logic                  done
);

    state_t     state;
    logic [2:0] op_q;

    assign instr_ready = (state == ST_IDLE);
    assign alu_a       = acc_out;
    assign mem_wr_data = acc_out;

    // Strobes are pre-set on the transition into their state so every output stays registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_NOP;
            mem_addr   <= '0;
            alu_b      <= '0;
            acc_out    <= '0;
            zero_flag  <= 1'b1;
            done       <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_wr_en  <= 1'b0;
            alu_sel    <= ALU_IDLE;
        end else begin
            done      <= 1'b0;
            mem_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        op_q     <= instr_op;
                        mem_addr <= instr_addr;
                        if (needs_fetch(instr_op)) begin
                            state      <= ST_FETCH;
                            mem_rd_req <= 1'b1;
                        end else if (instr_op == OP_STORE) begin
                            state     <= ST_WRITE;
                            mem_wr_en <= 1'b1;
                        end else begin
                            state   <= ST_EXEC;
                            alu_sel <= alu_sel_for(instr_op);
                        end
                    end
                end
                ST_FETCH: begin
                    if (mem_rd_valid) begin
                        alu_b      <= mem_rd_data;
                        mem_rd_req <= 1'b0;
                        alu_sel    <= alu_sel_for(op_q);
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_q != OP_NOP) begin
                        acc_out   <= alu_result;
                        zero_flag <= (alu_result == '0);
                    end
                    alu_sel <= ALU_IDLE;
                    done    <= 1'b1;
                    state   <= ST_IDLE;
                end
                ST_WRITE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_controller.sv
// Bench for alu_exec_controller: table of instructions with a done-driven scoreboard,
// plus hand sequences for reset during a fetch and a back-to-back STORE.
module tb_alu_exec_controller;
    import alu_exec_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [7:0]  instr_addr;
    logic        mem_rd_req;
    logic [7:0]  mem_addr;
    logic        mem_rd_valid;
    logic [11:0] mem_rd_data;
    logic        mem_wr_en;
    logic [11:0] mem_wr_data;
    logic [11:0] alu_a;
    logic [11:0] alu_b;
    logic [2:0]  alu_sel;
    logic [11:0] alu_result;
    logic [11:0] acc_out;
    logic        zero_flag;
    logic        done;

    alu_exec_controller #(.WIDTH(12), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_addr(instr_addr),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .acc_out(acc_out), .zero_flag(zero_flag), .done(done)
    );

    always #5 clk = ~clk;

    // Stand-in for the ALU that sits beside the controller.
    always_comb begin
        case (alu_sel)
            ALU_CLR:  alu_result = 12'h000;
            ALU_PASS: alu_result = alu_b;
            ALU_ADD:  alu_result = alu_a + alu_b;
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_MUL:  alu_result = alu_a * alu_b;
            ALU_INC:  alu_result = alu_a + 12'd1;
            default:  alu_result = alu_a;
        endcase
    end

    typedef struct {
        logic [11:0] acc;
        logic        zero;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  addr;
        logic [11:0] memval;
        int          lat;
        logic [11:0] acc;
        logic        zero;
        int          latency;
        int          rdreq;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vecs[17];
    logic [11:0] mem[256];
    int          cyc = 0;
    int          lat_cfg = 0;
    int          wait_cnt = 0;
    int          rdreq_cnt = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    int          passed = 0;
    int          total = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder, write capture and done scoreboard, all sampled on the falling edge.
    initial begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_rd_req && !rst) begin
                rdreq_cnt++;
                if (wait_cnt >= lat_cfg) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = mem[mem_addr];
                end else begin
                    wait_cnt++;
                    mem_rd_valid = 1'b0;
                end
            end else begin
                wait_cnt     = 0;
                mem_rd_valid = 1'b0;
            end
            if (mem_wr_en) begin
                wr_cnt++;
                mem[mem_addr] = mem_wr_data;
            end
            if (done) begin
                done_cnt++;
                if (sbq.size() == 0) begin
                    checkOutput("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput("acc_out", acc_out, e.acc);
                    checkOutput("zero_flag", zero_flag, e.zero);
                    checkOutput("latency", cyc - e.acc_cyc, 32'd2 + (e.acc_cyc >= 0 ? 0 : 0));
                end
            end
        end
    end

    task automatic drainScoreboard(input string name);
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sbq.size() != 0) begin
            checkOutput({name, "_timeout"}, sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int n = 0;
        exp_t e;
        mem[v.addr] = v.memval;
        lat_cfg     = v.lat;
        @(negedge clk);
        #2;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("ready_wait", instr_ready, 1);
        instr_valid = 1'b1;
        instr_op    = v.op;
        instr_addr  = v.addr;
        rdreq_cnt   = 0;
        // Bias the accept cycle so the monitor's fixed "2" check measures the vector's latency.
        e.acc  = v.acc;
        e.zero = v.zero;
        e.acc_cyc = cyc + v.latency - 2;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_op    = 3'($urandom_range(0, 7));
        instr_addr  = 8'($urandom_range(0, 255));
        drainScoreboard("done");
        checkOutput("rd_req_cycles", rdreq_cnt, v.rdreq);
    endtask

    initial begin
        int snap;
        exp_t e;
        vec_t v;
        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_op    = OP_NOP;
        instr_addr  = '0;

        vecs[0]  = '{OP_CLR,  8'h00, 12'h000, 0, 12'h000, 1'b1, 2, 0};
        vecs[1]  = '{OP_INC,  8'h00, 12'h000, 0, 12'h001, 1'b0, 2, 0};
        vecs[2]  = '{OP_INC,  8'h00, 12'h000, 0, 12'h002, 1'b0, 2, 0};
        vecs[3]  = '{OP_INC,  8'h00, 12'h000, 0, 12'h003, 1'b0, 2, 0};
        vecs[4]  = '{OP_PASS, 8'h11, 12'h005, 0, 12'h005, 1'b0, 3, 1};
        vecs[5]  = '{OP_ADD,  8'h10, 12'h007, 0, 12'h00C, 1'b0, 3, 1};
        vecs[6]  = '{OP_PASS, 8'h11, 12'h005, 2, 12'h005, 1'b0, 5, 3};
        vecs[7]  = '{OP_ADD,  8'h10, 12'h007, 3, 12'h00C, 1'b0, 6, 4};
        vecs[8]  = '{OP_PASS, 8'h11, 12'h007, 0, 12'h007, 1'b0, 3, 1};
        vecs[9]  = '{OP_SUB,  8'h12, 12'h007, 1, 12'h000, 1'b1, 4, 2};
        vecs[10] = '{OP_PASS, 8'h11, 12'h002, 0, 12'h002, 1'b0, 3, 1};
        vecs[11] = '{OP_SUB,  8'h12, 12'h005, 0, 12'hFFD, 1'b0, 3, 1};
        vecs[12] = '{OP_PASS, 8'h11, 12'h064, 0, 12'h064, 1'b0, 3, 1};
        vecs[13] = '{OP_MUL,  8'h13, 12'h032, 0, 12'h388, 1'b0, 3, 1};
        vecs[14] = '{OP_PASS, 8'h14, 12'h800, 0, 12'h800, 1'b0, 3, 1};
        vecs[15] = '{OP_NOP,  8'h00, 12'h000, 0, 12'h800, 1'b0, 2, 0};
        vecs[16] = '{OP_CLR,  8'h00, 12'h000, 0, 12'h000, 1'b1, 2, 0};

        repeat (2) @(negedge clk);
        checkOutput("rst_acc", acc_out, 12'h000);
        checkOutput("rst_zero", zero_flag, 1);
        checkOutput("rst_alu_sel", alu_sel, ALU_IDLE);
        checkOutput("rst_rd_req", mem_rd_req, 0);
        checkOutput("rst_wr_en", mem_wr_en, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", instr_ready, 1);
        checkOutput("rst_alu_b", alu_b, 12'h000);
        checkOutput("rst_mem_addr", mem_addr, 8'h00);
        rst = 1'b0;

        // Reset while FETCH waits on a slow memory.
        applyStimulus('{OP_INC, 8'h00, 12'h000, 0, 12'h001, 1'b0, 2, 0});
        lat_cfg = 1000;
        mem[8'h10] = 12'h007;
        @(negedge clk);
        #2;
        instr_valid = 1'b1;
        instr_op    = OP_ADD;
        instr_addr  = 8'h10;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("fetch_wait_rd_req", mem_rd_req, 1);
        snap = done_cnt;
        rst = 1'b1;
        #1;
        checkOutput("midop_acc", acc_out, 12'h000);
        checkOutput("midop_zero", zero_flag, 1);
        checkOutput("midop_rd_req", mem_rd_req, 0);
        checkOutput("midop_alu_sel", alu_sel, ALU_IDLE);
        checkOutput("midop_ready", instr_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        checkOutput("midop_no_done", done_cnt - snap, 0);
        checkOutput("midop_no_rd_req", mem_rd_req, 0);

        for (int i = 0; i < 17; i++) begin
            v = vecs[i];
            applyStimulus(v);
        end

        // STORE with instr_valid held so the following INC is accepted in the done cycle.
        applyStimulus('{OP_PASS, 8'h20, 12'h02A, 0, 12'h02A, 1'b0, 3, 1});
        wr_cnt = 0;
        @(negedge clk);
        #2;
        instr_valid = 1'b1;
        instr_op    = OP_STORE;
        instr_addr  = 8'h05;
        e = '{12'h02A, 1'b0, cyc};
        sbq.push_back(e);
        @(negedge clk);
        #2;
        checkOutput("store_wr_en", mem_wr_en, 1);
        checkOutput("store_addr", mem_addr, 8'h05);
        checkOutput("store_data", mem_wr_data, 12'h02A);
        checkOutput("store_ready_low", instr_ready, 0);
        instr_op   = OP_INC;
        instr_addr = 8'h00;
        e = '{12'h02B, 1'b0, cyc + 1};
        sbq.push_back(e);
        @(negedge clk);
        #2;
        checkOutput("store_done", done, 1);
        checkOutput("store_ready_done", instr_ready, 1);
        checkOutput("store_wr_en_drop", mem_wr_en, 0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        drainScoreboard("b2b");
        checkOutput("store_wr_count", wr_cnt, 1);
        checkOutput("store_mem", mem[8'h05], 12'h02A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
